// File: rtl/ex_mdu_pkg.sv
`default_nettype none
// ============================================================================
// ex_mdu_pkg : shared funct3 codes, writeback/hold constants, FSM state type
// Revision   : 1.0
// ============================================================================
package ex_mdu_pkg;

  localparam logic [2:0] INST_MUL    = 3'b000;
  localparam logic [2:0] INST_MULH   = 3'b001;
  localparam logic [2:0] INST_MULHSU = 3'b010;
  localparam logic [2:0] INST_MULHU  = 3'b011;
  localparam logic [2:0] INST_DIV    = 3'b100;
  localparam logic [2:0] INST_DIVU   = 3'b101;
  localparam logic [2:0] INST_REM    = 3'b110;
  localparam logic [2:0] INST_REMU   = 3'b111;

  localparam logic [6:0] INST_FUNCT7_M = 7'b000_0001;

  localparam logic       WriteEnable  = 1'b1;
  localparam logic       WriteDisable = 1'b0;
  localparam logic       HoldEnable   = 1'b1;
  localparam logic       HoldDisable  = 1'b0;
  localparam logic [4:0] ZeroReg      = 5'd0;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_MUL  = 2'd1,
    MDU_DIV  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

  function automatic logic is_m_funct7(input logic [6:0] funct7);
    return funct7 == INST_FUNCT7_M;
  endfunction

  // {rs1 signed, rs2 signed}; for divides bit 1 alone marks DIV/REM
  function automatic logic [1:0] mdu_op_signs(input logic [2:0] funct3);
    case (funct3)
      INST_MULH:           return 2'b11;
      INST_MULHSU:         return 2'b10;
      INST_DIV, INST_REM:  return 2'b11;
      INST_MUL, INST_MULHU,
      INST_DIVU, INST_REMU: return 2'b00;
      default:             return 2'b00;
    endcase
  endfunction

  function automatic int mdu_cnt_width(input int xlen, input int unroll);
    return $clog2(xlen / unroll + 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_div_core.sv
`default_nettype none
// ============================================================================
// mdu_div_core : restoring unsigned divider, DIV_UNROLL quotient bits per cycle
// Revision     : 1.0
// ============================================================================
module mdu_div_core
  import ex_mdu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int DIV_UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            done_o,
  output logic [XLEN-1:0] quot_o,
  output logic [XLEN-1:0] rem_o
);

  localparam int c_steps = XLEN / DIV_UNROLL;
  localparam int c_cnt_w = mdu_cnt_width(XLEN, DIV_UNROLL);

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_active;
  logic               r_done;
  logic [XLEN-1:0]    r_rem;
  logic [XLEN-1:0]    r_quot;
  logic [XLEN-1:0]    r_divisor;

  logic [XLEN-1:0]    w_rem_nx;
  logic [XLEN-1:0]    w_quot_nx;
  logic [XLEN-1:0]    w_div_in;
  logic [XLEN:0]      w_shift;
  logic [XLEN:0]      w_trial;

  // The start cycle already performs the first step on the raw operands
  always_comb begin
    w_rem_nx  = start_i ? '0         : r_rem;
    w_quot_nx = start_i ? dividend_i : r_quot;
    w_div_in  = start_i ? divisor_i  : r_divisor;
    w_shift   = '0;
    w_trial   = '0;
    for (int i = 0; i < DIV_UNROLL; i++) begin
      w_shift   = {w_rem_nx, w_quot_nx[XLEN-1]};
      w_trial   = w_shift - {1'b0, w_div_in};
      w_quot_nx = {w_quot_nx[XLEN-2:0], ~w_trial[XLEN]};
      w_rem_nx  = w_trial[XLEN] ? w_shift[XLEN-1:0] : w_trial[XLEN-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_active  <= 1'b0;
      r_done    <= 1'b0;
      r_rem     <= '0;
      r_quot    <= '0;
      r_divisor <= '0;
    end else if (abort_i) begin
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start_i || r_active) begin
        r_rem  <= w_rem_nx;
        r_quot <= w_quot_nx;
        if (start_i) begin
          r_divisor <= divisor_i;
          r_cnt     <= c_cnt_w'(1);
          r_active  <= (c_steps > 1);
          r_done    <= (c_steps == 1);
        end else begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_cnt_w'(c_steps - 1)) begin
            r_active <= 1'b0;
            r_done   <= 1'b1;
          end
        end
      end
    end
  end

  assign done_o = r_done;
  assign quot_o = r_quot;
  assign rem_o  = r_rem;

endmodule
`default_nettype wire

// File: rtl/ex_mdu.sv
`default_nettype none
// ============================================================================
// ex_mdu   : RV32M multiply/divide execute unit with pipeline hold and writeback
// Revision : 1.0
// ============================================================================
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2,
  parameter int DIV_UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            hold_flag_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_wen_o
);

  localparam int              c_cnt_w   = mdu_cnt_width(XLEN, DIV_UNROLL);
  localparam int              c_prod_w  = 2 * XLEN + 2;
  localparam logic [XLEN-1:0] c_int_min = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e          r_state;
  mdu_state_e          w_state_nx;
  logic [2:0]          r_funct3;
  logic [1:0]          r_signs;
  logic [XLEN-1:0]     r_op1;
  logic [XLEN-1:0]     r_op2;
  logic [4:0]          r_rd;
  logic [c_cnt_w-1:0]  r_cnt;
  logic                r_neg_q;
  logic                r_neg_r;
  logic                r_fix_pending;
  logic [XLEN-1:0]     r_fixed;

  logic                w_accept;
  logic [1:0]          w_signs;
  logic                w_div_zero;
  logic                w_overflow;
  logic                w_special;
  logic [XLEN-1:0]     w_abs1;
  logic [XLEN-1:0]     w_abs2;
  logic [XLEN-1:0]     w_special_res;
  logic [XLEN-1:0]     w_mul_res;
  logic [XLEN-1:0]     w_result;
  logic [4:0]          w_rd_sel;
  logic                w_done_nx;
  logic                w_div_done;
  logic [XLEN-1:0]     w_quot;
  logic [XLEN-1:0]     w_rem;

  logic signed [c_prod_w-1:0] w_pa;
  logic signed [c_prod_w-1:0] w_pb;
  logic signed [c_prod_w-1:0] w_product;
  logic [2*XLEN-1:0]          w_prod_lo;
  logic [2*XLEN-1:0]          w_prod_tap;
  logic                       w_unused_prod;

  assign w_accept   = (r_state == MDU_IDLE) && start_i && !flush_i;
  assign w_signs    = mdu_op_signs(funct3_i);
  assign w_div_zero = (op2_i == '0);
  assign w_overflow = w_signs[1] && (op1_i == c_int_min) && (op2_i == '1);
  assign w_special  = funct3_i[2] && (w_div_zero || w_overflow);
  assign w_abs1     = (w_signs[1] && op1_i[XLEN-1]) ? -op1_i : op1_i;
  assign w_abs2     = (w_signs[1] && op2_i[XLEN-1]) ? -op2_i : op2_i;

  // funct3[1] selects the remainder flavour of the divide ops
  assign w_special_res = funct3_i[1] ? (w_div_zero ? op1_i : '0)
                                     : (w_div_zero ? '1    : op1_i);

  mdu_div_core #(
    .XLEN       (XLEN),
    .DIV_UNROLL (DIV_UNROLL)
  ) u_div_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (w_accept && funct3_i[2] && !w_special),
    .abort_i    (flush_i && (r_state == MDU_DIV)),
    .dividend_i (w_abs1),
    .divisor_i  (w_abs2),
    .done_o     (w_div_done),
    .quot_o     (w_quot),
    .rem_o      (w_rem)
  );

  assign w_pa          = {{(XLEN+2){r_signs[1] & r_op1[XLEN-1]}}, r_op1};
  assign w_pb          = {{(XLEN+2){r_signs[0] & r_op2[XLEN-1]}}, r_op2};
  assign w_product     = w_pa * w_pb;
  assign w_prod_lo     = w_product[2*XLEN-1:0];
  assign w_unused_prod = ^w_product[c_prod_w-1:2*XLEN];

  // Operand latch plus MUL_STAGES-1 product registers feed the output register
  generate
    if (MUL_STAGES == 1) begin : g_mul_direct
      assign w_prod_tap = w_prod_lo;
    end else begin : g_mul_pipe
      logic [2*XLEN-1:0] r_pipe [MUL_STAGES-1];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < MUL_STAGES - 1; i++) r_pipe[i] <= '0;
        end else begin
          r_pipe[0] <= w_prod_lo;
          for (int i = 1; i < MUL_STAGES - 1; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end
      assign w_prod_tap = r_pipe[MUL_STAGES-2];
    end
  endgenerate

  assign w_mul_res = (r_funct3 == INST_MUL) ? w_prod_tap[XLEN-1:0]
                                            : w_prod_tap[2*XLEN-1:XLEN];

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      MDU_IDLE: begin
        if (w_accept) begin
          if (!funct3_i[2])   w_state_nx = MDU_MUL;
          else if (w_special) w_state_nx = MDU_DONE;
          else                w_state_nx = MDU_DIV;
        end
      end
      MDU_MUL: begin
        if (flush_i)                                       w_state_nx = MDU_IDLE;
        else if (r_cnt == c_cnt_w'(MUL_STAGES - 1))        w_state_nx = MDU_DONE;
      end
      MDU_DIV: begin
        if (flush_i)                                       w_state_nx = MDU_IDLE;
        else if (r_fix_pending || (w_div_done && !r_signs[1])) w_state_nx = MDU_DONE;
      end
      MDU_DONE: w_state_nx = MDU_IDLE;
      default:  w_state_nx = MDU_IDLE;
    endcase
  end

  always_comb begin
    w_result = '0;
    case (r_state)
      MDU_IDLE: w_result = w_special_res;
      MDU_MUL:  w_result = w_mul_res;
      MDU_DIV:  w_result = r_fix_pending ? r_fixed : (r_funct3[1] ? w_rem : w_quot);
      default:  w_result = '0;
    endcase
  end

  assign w_rd_sel  = (r_state == MDU_IDLE) ? rd_addr_i : r_rd;
  assign w_done_nx = (w_state_nx == MDU_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= MDU_IDLE;
      r_funct3      <= '0;
      r_signs       <= '0;
      r_op1         <= '0;
      r_op2         <= '0;
      r_rd          <= ZeroReg;
      r_cnt         <= '0;
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      r_fix_pending <= 1'b0;
      r_fixed       <= '0;
      rd_wen_o      <= WriteDisable;
      rd_addr_o     <= ZeroReg;
      rd_data_o     <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= (r_state == MDU_MUL) ? r_cnt + 1'b1 : '0;
      if (w_accept) begin
        r_funct3 <= funct3_i;
        r_signs  <= w_signs;
        r_op1    <= op1_i;
        r_op2    <= op2_i;
        r_rd     <= rd_addr_i;
        r_neg_q  <= w_signs[1] && (op1_i[XLEN-1] ^ op2_i[XLEN-1]);
        r_neg_r  <= w_signs[1] && op1_i[XLEN-1];
      end
      // Signed divides spend one extra cycle applying the result sign
      r_fix_pending <= (r_state == MDU_DIV) && w_div_done && r_signs[1] && !flush_i;
      if (w_div_done) begin
        r_fixed <= r_funct3[1] ? (r_neg_r ? -w_rem : w_rem)
                               : (r_neg_q ? -w_quot : w_quot);
      end
      rd_wen_o  <= w_done_nx ? WriteEnable : WriteDisable;
      rd_addr_o <= w_done_nx ? w_rd_sel : ZeroReg;
      rd_data_o <= w_done_nx ? w_result : '0;
    end
  end

  assign busy_o      = (r_state != MDU_IDLE);
  assign hold_flag_o = ((r_state == MDU_IDLE) && start_i) || (r_state == MDU_MUL) ||
                       (r_state == MDU_DIV) ? HoldEnable : HoldDisable;

endmodule
`default_nettype wire

// File: tb/tb_ex_mdu.sv
`default_nettype none
// ============================================================================
// tb_ex_mdu : scoreboard bench for ex_mdu (multiply, divide, specials, flush, reset)
// Revision  : 1.0
// ============================================================================
module tb_ex_mdu;

  localparam int XLEN       = 32;
  localparam int MUL_STAGES = 2;
  localparam int DIV_UNROLL = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] op1_i;
  logic [31:0] op2_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic        busy_o;
  logic        hold_flag_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        rd_wen_o;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ex_mdu #(
    .XLEN       (XLEN),
    .MUL_STAGES (MUL_STAGES),
    .DIV_UNROLL (DIV_UNROLL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .funct3_i    (funct3_i),
    .op1_i       (op1_i),
    .op2_i       (op2_i),
    .rd_addr_i   (rd_addr_i),
    .flush_i     (flush_i),
    .busy_o      (busy_o),
    .hold_flag_o (hold_flag_o),
    .rd_addr_o   (rd_addr_o),
    .rd_data_o   (rd_data_o),
    .rd_wen_o    (rd_wen_o)
  );

  function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return MUL_STAGES + 1;
    if (b == 32'h0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return XLEN / DIV_UNROLL + 1 + (f3[0] ? 0 : 1);
  endfunction

  // Drives one start pulse; scrambles the inputs after the accepting edge
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit push);
    exp_t e;
    @(negedge clk);
    funct3_i = f3; op1_i = a; op2_i = b; rd_addr_i = rd; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; funct3_i = ~f3; op1_i = ~a; op2_i = ~b; rd_addr_i = ~rd;
    if (push) begin
      e.rd = rd; e.data = ref_mdu(f3, a, b); e.lat = exp_lat(f3, a, b);
      sb.push_back(e);
    end
  endtask

  task automatic wait_wen(output int lat, output int holds);
    lat = -1; holds = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (rd_wen_o) begin lat = k; return; end
      if (hold_flag_o) holds++;
    end
  endtask

  task automatic test_reset;
    total++;
    if ({busy_o, hold_flag_o, rd_wen_o, rd_addr_o, rd_data_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b hold=%b wen=%b addr=%h data=%h want all 0",
               busy_o, hold_flag_o, rd_wen_o, rd_addr_o, rd_data_o);
    end
  endtask

  task automatic test_mul;
    int lat, holds; exp_t e;
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1);
    wait_wen(lat, holds);
    e = sb.pop_front();
    total++; if (rd_data_o !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mul_data: got %h want %h", rd_data_o, 32'hFFFF_FFEB); end
    total++; if (rd_addr_o !== e.rd) begin bad++; $display("FAIL mul_rd: got %0d want %0d", rd_addr_o, e.rd); end
    total++; if (lat !== e.lat) begin bad++; $display("FAIL mul_latency: got %0d want %0d", lat, e.lat); end
    total++; if (holds !== MUL_STAGES) begin bad++; $display("FAIL mul_hold_cycles: got %0d want %0d", holds, MUL_STAGES); end
    @(negedge clk);
    total++; if (rd_wen_o !== 1'b0) begin bad++; $display("FAIL mul_wen_pulse: got %b want 0", rd_wen_o); end
    for (int i = 0; i < 6; i++) begin
      issue(3'($urandom_range(0, 3)), $urandom, $urandom, 5'($urandom_range(0, 31)), 1'b1);
      wait_wen(lat, holds);
      e = sb.pop_front();
      total++; if (rd_data_o !== e.data || lat !== e.lat) begin
        bad++; $display("FAIL mul_rand%0d: got %h lat %0d want %h lat %0d", i, rd_data_o, lat, e.data, e.lat);
      end
    end
  endtask

  task automatic test_mulh;
    int lat, holds; exp_t e;
    logic [31:0] want [3];
    want[0] = 32'hFFFF_FFFE; want[1] = 32'h0000_0000; want[2] = 32'hFFFF_FFFF;
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b1);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b0);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0);
    // Only the first start lands in IDLE; the rest arrive while busy
    wait_wen(lat, holds);
    e = sb.pop_front();
    total++; if (rd_data_o !== want[0]) begin bad++; $display("FAIL mulhu: got %h want %h", rd_data_o, want[0]); end
    for (int i = 1; i < 3; i++) begin
      issue(3'(i == 1 ? 1 : 2), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'(i), 1'b1);
      wait_wen(lat, holds);
      e = sb.pop_front();
      total++; if (rd_data_o !== want[i] || rd_data_o !== e.data) begin
        bad++; $display("FAIL mulh_%0d: got %h want %h", i, rd_data_o, want[i]);
      end
    end
  endtask

  task automatic test_div;
    int lat, holds; exp_t e;
    logic [31:0] want [2];
    want[0] = 32'hFFFF_FFFD; want[1] = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      issue(i == 0 ? 3'd4 : 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd9, 1'b1);
      wait_wen(lat, holds);
      e = sb.pop_front();
      total++; if (rd_data_o !== want[i]) begin bad++; $display("FAIL div_signed%0d: got %h want %h", i, rd_data_o, want[i]); end
      total++; if (lat !== 34) begin bad++; $display("FAIL div_latency%0d: got %0d want 34", i, lat); end
    end
    for (int i = 0; i < 8; i++) begin
      logic [31:0] b;
      b = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      issue(3'($urandom_range(4, 7)), $urandom, b, 5'($urandom_range(0, 31)), 1'b1);
      wait_wen(lat, holds);
      e = sb.pop_front();
      total++; if (rd_data_o !== e.data || lat !== e.lat || rd_addr_o !== e.rd) begin
        bad++; $display("FAIL div_rand%0d: got %h lat %0d rd %0d want %h lat %0d rd %0d",
                        i, rd_data_o, lat, rd_addr_o, e.data, e.lat, e.rd);
      end
    end
  endtask

  task automatic test_special;
    int lat, holds; exp_t e;
    logic [2:0]  f3 [4];
    logic [31:0] a  [4];
    logic [31:0] b  [4];
    logic [31:0] w  [4];
    f3[0] = 3'd5; a[0] = 32'd5;          b[0] = 32'd0;          w[0] = 32'hFFFF_FFFF;
    f3[1] = 3'd7; a[1] = 32'd5;          b[1] = 32'd0;          w[1] = 32'd5;
    f3[2] = 3'd4; a[2] = 32'h8000_0000;  b[2] = 32'hFFFF_FFFF;  w[2] = 32'h8000_0000;
    f3[3] = 3'd6; a[3] = 32'h8000_0000;  b[3] = 32'hFFFF_FFFF;  w[3] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      issue(f3[i], a[i], b[i], 5'(20 + i), 1'b1);
      wait_wen(lat, holds);
      e = sb.pop_front();
      total++; if (rd_data_o !== w[i] || lat !== 1 || rd_addr_o !== 5'(20 + i)) begin
        bad++; $display("FAIL special%0d: got %h lat %0d rd %0d want %h lat 1 rd %0d",
                        i, rd_data_o, lat, rd_addr_o, w[i], 20 + i);
      end
    end
  endtask

  task automatic test_flush;
    int lat, holds, extra; exp_t e;
    issue(3'd5, 32'd1000, 32'd3, 5'd7, 1'b0);
    repeat (9) @(negedge clk);
    @(posedge clk); #1; flush_i = 1'b1;
    @(posedge clk); #1; flush_i = 1'b0;
    total++; if (busy_o !== 1'b0 || hold_flag_o !== 1'b0) begin
      bad++; $display("FAIL flush_busy: got busy=%b hold=%b want 0 0", busy_o, hold_flag_o);
    end
    issue(3'd0, 32'd12, 32'd11, 5'd8, 1'b1);
    wait_wen(lat, holds);
    e = sb.pop_front();
    total++; if (rd_data_o !== e.data || lat !== e.lat || rd_addr_o !== 5'd8) begin
      bad++; $display("FAIL flush_restart: got %h lat %0d rd %0d want %h lat %0d rd 8", rd_data_o, lat, rd_addr_o, e.data, e.lat);
    end
    extra = 0;
    repeat (40) begin @(negedge clk); if (rd_wen_o) extra++; end
    total++; if (extra !== 0) begin bad++; $display("FAIL flush_no_write: got %0d writes want 0", extra); end
  endtask

  task automatic test_start_flush_idle;
    int extra;
    @(negedge clk);
    funct3_i = 3'd0; op1_i = 32'd3; op2_i = 32'd3; rd_addr_i = 5'd4; start_i = 1'b1; flush_i = 1'b1;
    @(posedge clk); #1; start_i = 1'b0; flush_i = 1'b0;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL start_flush_busy: got %b want 0", busy_o); end
    extra = 0;
    repeat (6) begin @(negedge clk); if (rd_wen_o) extra++; end
    total++; if (extra !== 0) begin bad++; $display("FAIL start_flush_write: got %0d writes want 0", extra); end
  endtask

  task automatic test_busy_start;
    int lat, holds, extra; exp_t e;
    issue(3'd5, 32'd100, 32'd7, 5'd11, 1'b1);
    repeat (5) @(negedge clk);
    funct3_i = 3'd0; op1_i = 32'd3; op2_i = 32'd4; rd_addr_i = 5'd12; start_i = 1'b1;
    @(posedge clk); #1; start_i = 1'b0;
    wait_wen(lat, holds);
    e = sb.pop_front();
    total++; if (rd_data_o !== e.data || rd_addr_o !== e.rd) begin
      bad++; $display("FAIL busy_start_result: got %h rd %0d want %h rd %0d", rd_data_o, rd_addr_o, e.data, e.rd);
    end
    extra = 0;
    repeat (40) begin @(negedge clk); if (rd_wen_o) extra++; end
    total++; if (extra !== 0) begin bad++; $display("FAIL busy_start_extra: got %0d writes want 0", extra); end
  endtask

  task automatic test_reset_mid;
    int lat, holds, extra; exp_t e;
    issue(3'd4, 32'hFFFF_0000, 32'd5, 5'd13, 1'b0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0; #1;
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    extra = 0;
    repeat (50) begin @(negedge clk); if (rd_wen_o) extra++; end
    total++; if (extra !== 0) begin bad++; $display("FAIL reset_mid_write: got %0d writes want 0", extra); end
    issue(3'd0, 32'd6, 32'd9, 5'd14, 1'b1);
    wait_wen(lat, holds);
    e = sb.pop_front();
    total++; if (rd_data_o !== e.data || lat !== e.lat) begin
      bad++; $display("FAIL reset_recover: got %h lat %0d want %h lat %0d", rd_data_o, lat, e.data, e.lat);
    end
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    funct3_i = '0; op1_i = '0; op2_i = '0; rd_addr_i = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_flush();
    test_start_flush_idle();
    test_busy_start();
    test_reset_mid();
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL scoreboard_left: got %0d entries want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
